// File: rtl/ray_cast_nearest.sv
// ray_cast_nearest: streams wall segments against one latched ray and returns the nearest hit.
module ray_cast_nearest #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TEX_BITS    = 6,
  parameter int TEX_ID_BITS = 2,
  parameter int IDX_BITS    = 8,
  parameter int SMALL_DEN   = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ray_valid,
  output logic                              ray_ready,
  input  logic signed [WIDTH-1:0]           ray_x1,
  input  logic signed [WIDTH-1:0]           ray_y1,
  input  logic signed [WIDTH-1:0]           ray_x2,
  input  logic signed [WIDTH-1:0]           ray_y2,
  input  logic                              wall_valid,
  output logic                              wall_ready,
  input  logic signed [WIDTH-1:0]           wall_x3,
  input  logic signed [WIDTH-1:0]           wall_y3,
  input  logic signed [WIDTH-1:0]           wall_x4,
  input  logic signed [WIDTH-1:0]           wall_y4,
  input  logic [TEX_ID_BITS-1:0]            wall_tex,
  input  logic                              wall_last,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              result_hit,
  output logic [WIDTH-1:0]                  result_t,
  output logic [TEX_ID_BITS+TEX_BITS-1:0]   result_uv,
  output logic [IDX_BITS-1:0]               result_idx
);
  localparam int PW = 2*WIDTH+2;
  localparam int DW = PW+WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] IDLE = 3'd0, WAIT_WALL = 3'd1, CHECK = 3'd2, DIV_T = 3'd3,
                         DIV_U = 3'd4, UPDATE = 3'd5, DONE = 3'd6;
  logic [2:0] state;
  logic signed [WIDTH-1:0] x1, y1, x2, y2;
  logic signed [PW-1:0] den, tn, un;
  logic [TEX_ID_BITS-1:0] tex;
  logic last, cand, sat;
  logic [DW-1:0] rem, dv;
  logic [WIDTH-1:0] q, t_val;
  logic [TEX_BITS-1:0] u_val;
  logic [CW-1:0] cnt;
  logic [IDX_BITS-1:0] wall_cnt;
  logic signed [PW-1:0] rdx, rdy, wdx, wdy, ox, oy;
  logic [PW-1:0] aden, atn, aun;
  logic reject, ge;
  logic [DW-1:0] rem_n;
  logic [WIDTH-1:0] q_n;
  assign ray_ready    = state == IDLE;
  assign wall_ready   = state == WAIT_WALL;
  assign result_valid = state == DONE;
  assign rdx = PW'(x1) - PW'(x2);
  assign rdy = PW'(y1) - PW'(y2);
  assign wdx = PW'(wall_x3) - PW'(wall_x4);
  assign wdy = PW'(wall_y3) - PW'(wall_y4);
  assign ox  = PW'(x1) - PW'(wall_x3);
  assign oy  = PW'(y1) - PW'(wall_y3);
  assign aden = den[PW-1] ? -den : den;
  assign atn  = tn[PW-1] ? -tn : tn;
  assign aun  = un[PW-1] ? -un : un;
  // t and u must share den's sign to be non-negative; u beyond 1 means the hit is off the segment
  assign reject = (aden < PW'(SMALL_DEN)) || (|tn && tn[PW-1] != den[PW-1]) ||
                  (|un && un[PW-1] != den[PW-1]) || (aun > aden);
  assign ge    = rem >= dv;
  assign rem_n = ge ? rem - dv : rem;
  assign q_n   = {q[WIDTH-2:0], ge};
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      result_hit <= 1'b0;
      result_t   <= '1;
      result_uv  <= '0;
      result_idx <= '0;
    end else begin
      case (state)
        IDLE: if (ray_valid) begin
          x1         <= ray_x1;
          y1         <= ray_y1;
          x2         <= ray_x2;
          y2         <= ray_y2;
          result_hit <= 1'b0;
          result_t   <= '1;
          result_uv  <= '0;
          result_idx <= '0;
          wall_cnt   <= '0;
          state      <= WAIT_WALL;
        end
        WAIT_WALL: if (wall_valid) begin
          den   <= rdx*wdy - rdy*wdx;
          tn    <= ox*wdy - oy*wdx;
          un    <= rdy*ox - rdx*oy;
          tex   <= wall_tex;
          last  <= wall_last;
          state <= CHECK;
        end
        CHECK: begin
          // quotient must fit in WIDTH bits, otherwise t saturates
          cand  <= !reject;
          rem   <= DW'(atn) << FRAC_BITS;
          dv    <= DW'(aden) << (WIDTH-1);
          sat   <= DW'(atn) >= (DW'(aden) << (WIDTH-FRAC_BITS));
          q     <= '0;
          cnt   <= CW'(WIDTH-1);
          state <= reject ? UPDATE : DIV_T;
        end
        DIV_T: begin
          rem <= rem_n;
          dv  <= dv >> 1;
          q   <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            t_val <= sat ? '1 : q_n;
            rem   <= DW'(aun) << TEX_BITS;
            dv    <= DW'(aden) << (TEX_BITS-1);
            sat   <= aun >= aden;
            q     <= '0;
            cnt   <= CW'(TEX_BITS-1);
            state <= DIV_U;
          end
        end
        DIV_U: begin
          rem <= rem_n;
          dv  <= dv >> 1;
          q   <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            u_val <= sat ? '1 : q_n[TEX_BITS-1:0];
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (cand && (!result_hit || t_val < result_t)) begin
            result_hit <= 1'b1;
            result_t   <= t_val;
            result_uv  <= {tex, u_val};
            result_idx <= wall_cnt;
          end
          wall_cnt <= wall_cnt + 1'b1;
          state    <= last ? DONE : WAIT_WALL;
        end
        DONE: if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_cast_nearest.sv
// tb_ray_cast_nearest: directed and random ray/wall streams checked against an arithmetic model.
module tb_ray_cast_nearest;
  typedef struct {
    logic signed [15:0] x3, y3, x4, y4;
    logic [1:0] tex;
  } wall_t;
  localparam int LAT_HIT = 3 + 16 + 6;
  localparam int LAT_REJ = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic ray_valid = 1'b0, ray_ready;
  logic signed [15:0] ray_x1 = '0, ray_y1 = '0, ray_x2 = '0, ray_y2 = '0;
  logic wall_valid = 1'b0, wall_ready;
  logic signed [15:0] wall_x3 = '0, wall_y3 = '0, wall_x4 = '0, wall_y4 = '0;
  logic [1:0] wall_tex = '0;
  logic wall_last = 1'b0;
  logic result_valid, result_ready = 1'b0, result_hit;
  logic [15:0] result_t;
  logic [7:0] result_uv, result_idx;
  int cyc = 0, checks = 0, fails = 0;
  wall_t walls[$];
  bit wcand[$];
  logic r_hit;
  logic [15:0] r_t;
  logic [7:0] r_uv, r_idx;

  ray_cast_nearest dut (
    .clk(clk), .reset(reset),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_x1(ray_x1), .ray_y1(ray_y1), .ray_x2(ray_x2), .ray_y2(ray_y2),
    .wall_valid(wall_valid), .wall_ready(wall_ready),
    .wall_x3(wall_x3), .wall_y3(wall_y3), .wall_x4(wall_x4), .wall_y4(wall_y4),
    .wall_tex(wall_tex), .wall_last(wall_last),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hit(result_hit), .result_t(result_t), .result_uv(result_uv), .result_idx(result_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wall_t mk(input logic signed [15:0] x3, y3, x4, y4, input logic [1:0] tex);
    wall_t w;
    w.x3 = x3; w.y3 = y3; w.x4 = x4; w.y4 = y4; w.tex = tex;
    return w;
  endfunction

  function automatic logic signed [15:0] rnd_coord();
    int c;
    c = int'($urandom_range(0, 8192)) - 4096;
    return c[15:0];
  endfunction

  // intersection straight from the line equations, using wide integer division
  function automatic void model(input longint x1, y1, x2, y2, output logic eh,
                                output logic [15:0] et, output logic [7:0] euv, output logic [7:0] eidx);
    longint rdx, rdy, wdx, wdy, ox, oy, den, tn, un, ad, at, au, t, u;
    bit ok;
    eh = 1'b0; et = '1; euv = '0; eidx = '0;
    wcand.delete();
    foreach (walls[i]) begin
      rdx = x1 - x2; rdy = y1 - y2;
      wdx = longint'(walls[i].x3) - longint'(walls[i].x4);
      wdy = longint'(walls[i].y3) - longint'(walls[i].y4);
      ox = x1 - longint'(walls[i].x3); oy = y1 - longint'(walls[i].y3);
      den = rdx*wdy - rdy*wdx;
      tn = ox*wdy - oy*wdx;
      un = -(rdx*oy - rdy*ox);
      ad = den < 0 ? -den : den;
      at = tn < 0 ? -tn : tn;
      au = un < 0 ? -un : un;
      ok = ad >= 256 && !(tn != 0 && ((tn < 0) != (den < 0))) &&
           !(un != 0 && ((un < 0) != (den < 0))) && au <= ad;
      wcand.push_back(ok);
      if (ok) begin
        t = (at << 8) / ad;
        if (t > 65535) t = 65535;
        u = (au << 6) / ad;
        if (u > 63) u = 63;
        if (!eh || t < longint'(et)) begin
          eh = 1'b1; et = t[15:0]; euv = {walls[i].tex, u[5:0]}; eidx = i[7:0];
        end
      end
    end
  endfunction

  task automatic send_ray(input logic signed [15:0] x1, y1, x2, y2);
    int n = 0;
    ray_x1 = x1; ray_y1 = y1; ray_x2 = x2; ray_y2 = y2; ray_valid = 1'b1;
    while (!ray_ready && n < 200) begin @(negedge clk); n++; end
    check("ray_handshake_in_time", n < 200, 1);
    @(posedge clk); @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic send_wall(input wall_t w, input logic last, input int gap, output int acc);
    int n = 0;
    repeat (gap) @(negedge clk);
    wall_x3 = w.x3; wall_y3 = w.y3; wall_x4 = w.x4; wall_y4 = w.y4;
    wall_tex = w.tex; wall_last = last; wall_valid = 1'b1;
    while (!wall_ready && n < 200) begin @(negedge clk); n++; end
    check("wall_handshake_in_time", n < 200, 1);
    @(posedge clk); @(negedge clk);
    acc = cyc;
    wall_valid = 1'b0;
  endtask

  task automatic run_ray(input logic signed [15:0] x1, y1, x2, y2, input int maxgap,
                         input int hold, input bit timing);
    logic eh;
    logic [15:0] et;
    logic [7:0] euv, eidx;
    int acc = 0, pacc = 0, n = 0;
    model(x1, y1, x2, y2, eh, et, euv, eidx);
    send_ray(x1, y1, x2, y2);
    foreach (walls[i]) begin
      send_wall(walls[i], i == walls.size() - 1, maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0, acc);
      if (timing && i > 0) check("wall_spacing", acc - pacc, wcand[i-1] ? LAT_HIT : LAT_REJ);
      pacc = acc;
    end
    while (!result_valid && n < 400) begin @(negedge clk); n++; end
    check("result_in_time", n < 400, 1);
    if (timing) check("result_latency", cyc - pacc + 1, wcand[walls.size()-1] ? LAT_HIT : LAT_REJ);
    r_hit = result_hit; r_t = result_t; r_uv = result_uv; r_idx = result_idx;
    check("hit", r_hit, eh);
    check("t", r_t, et);
    check("uv", r_uv, euv);
    check("idx", r_idx, eidx);
    if (hold > 0) ray_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_t", result_t, et);
      check("hold_uv", result_uv, euv);
      check("hold_ray_ready", ray_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    result_ready = 1'b0;
    check("idle_after_result", ray_ready, 1);
    ray_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ray_ready"}, ray_ready, 1);
    check({tag, "_wall_ready"}, wall_ready, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_hit"}, result_hit, 0);
    check({tag, "_t"}, result_t, 16'hFFFF);
    check({tag, "_uv"}, result_uv, 0);
    check({tag, "_idx"}, result_idx, 0);
  endtask

  initial begin
    int acc;
    logic signed [15:0] rx, ry;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    walls = '{mk(16'sh0500, -16'sh0200, 16'sh0500, 16'sh0200, 2'd2)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 0, 1);
    check("single_t", r_t, 16'h0080);
    check("single_uv", r_uv, 8'hA0);
    check("single_idx", r_idx, 0);

    walls = '{mk(16'sh0500, -16'sh0200, 16'sh0500, 16'sh0200, 2'd0),
              mk(16'sh0300, -16'sh0200, 16'sh0300, 16'sh0200, 2'd1),
              mk(16'sh0300, -16'sh0200, 16'sh0300, 16'sh0200, 2'd3)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 0, 1);
    check("nearest_t", r_t, 16'h004C);
    check("nearest_idx", r_idx, 1);
    check("nearest_uv", r_uv, 8'h60);

    walls = '{mk(16'sh0000, 16'sh0100, 16'sh0A00, 16'sh0100, 2'd1),
              mk(-16'sh0500, -16'sh0200, -16'sh0500, 16'sh0200, 2'd2),
              mk(16'sh0500, 16'sh0100, 16'sh0500, 16'sh0300, 2'd3)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 0, 1);
    check("reject_hit", r_hit, 0);
    check("reject_t", r_t, 16'hFFFF);

    walls = '{mk(16'sh0500, -16'sh0200, 16'sh0500, 16'sh0000, 2'd1)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 0, 1);
    check("u_one_clamp", r_uv, {2'd1, 6'd63});

    walls = '{mk(16'sh6400, -16'sh0200, 16'sh6400, 16'sh0200, 2'd0)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0001, 16'sh0000, 0, 0, 1);
    check("sat_hit", r_hit, 1);
    check("sat_t", r_t, 16'hFFFF);

    walls = '{mk(16'sh0500, -16'sh0200, 16'sh0500, 16'sh0200, 2'd2)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 10, 0);

    for (int r = 0; r < 6; r++) begin
      walls.delete();
      for (int w = 0; w < 1 + int'($urandom_range(0, 4)); w++)
        walls.push_back(mk(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), 2'($urandom_range(0, 3))));
      rx = rnd_coord(); ry = rnd_coord();
      run_ray(16'sh0000, 16'sh0000, rx, ry, 0, 0, 0);
      run_ray(16'sh0000, 16'sh0000, rx, ry, 3, 0, 0);
    end

    walls = '{mk(16'sh0100, -16'sh0200, 16'sh0100, 16'sh0200, 2'd3),
              mk(16'sh0200, -16'sh0200, 16'sh0200, 16'sh0200, 2'd1)};
    send_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000);
    send_wall(walls[0], 1'b0, 0, acc);
    send_wall(walls[1], 1'b0, 0, acc);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
    walls = '{mk(16'sh0500, -16'sh0200, 16'sh0500, 16'sh0200, 2'd2)};
    run_ray(16'sh0000, 16'sh0000, 16'sh0A00, 16'sh0000, 0, 0, 1);
    check("fresh_t", r_t, 16'h0080);
    check("fresh_idx", r_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
